// File: rtl/booth_r4_ctrl.sv
// Sequential radix-4 Booth control stage for an 8x8 signed multiplier.
// Recodes one Booth digit per cycle, drives an external 16-bit adder with the
// shifted/inverted partial product and accumulates the returned sum.
module booth_r4_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  mcand_i,
  input  logic [7:0]  mplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] product_o,
  output logic [15:0] add_a_o,
  output logic [15:0] add_b_o,
  output logic        add_cin_o,
  input  logic [15:0] add_sum_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] m_q, m_d;
  logic [8:0]  q_q, q_d;
  logic [15:0] acc_q, acc_d;

  logic [2:0]  triplet;
  logic        digitZero;
  logic        digitNeg;
  logic        digitDbl;
  logic [15:0] multiple;
  logic [15:0] partial;

  // Register bank; reset clears everything so outputs drop to zero at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      m_q     <= 16'd0;
      q_q     <= 9'd0;
      acc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic: capture operands on acceptance, accumulate while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          m_d     = {{8{mcand_i[7]}}, mcand_i};
          q_d     = {mplier_i, 1'b0};
          acc_d   = 16'd0;
          cnt_d   = 2'd0;
        end
      end
      RUN: begin
        acc_d = add_sum_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select the overlapping multiplier triplet for the current digit.
  always_comb begin
    triplet = 3'b000;
    case (cnt_q)
      2'd0: triplet = q_q[2:0];
      2'd1: triplet = q_q[4:2];
      2'd2: triplet = q_q[6:4];
      2'd3: triplet = q_q[8:6];
      default: triplet = 3'b000;
    endcase
  end

  // Booth recoding of the triplet into zero / sign / 1x-or-2x magnitude.
  always_comb begin
    digitZero = 1'b0;
    digitNeg  = 1'b0;
    digitDbl  = 1'b0;
    case (triplet)
      3'b000, 3'b111: digitZero = 1'b1;
      3'b001, 3'b010: digitNeg  = 1'b0;
      3'b011:         digitDbl  = 1'b1;
      3'b100: begin
        digitNeg = 1'b1;
        digitDbl = 1'b1;
      end
      3'b101, 3'b110: digitNeg  = 1'b1;
      default:        digitZero = 1'b1;
    endcase
  end

  // Partial product: pick M or 2M, then weight it by 4^digit.
  always_comb begin
    multiple = digitDbl ? {m_q[14:0], 1'b0} : m_q;
    partial  = multiple << {cnt_q, 1'b0};
  end

  // Adder operand drive; negation is ~P plus carry-in, idle outside RUN.
  always_comb begin
    add_a_o   = 16'd0;
    add_b_o   = 16'd0;
    add_cin_o = 1'b0;
    if (state_q == RUN) begin
      add_a_o = acc_q;
      if (!digitZero) begin
        add_b_o   = digitNeg ? ~partial : partial;
        add_cin_o = digitNeg;
      end
    end
  end

  // Status outputs are decoded straight from the state register.
  always_comb begin
    busy_o    = (state_q != IDLE);
    done_o    = (state_q == DONE);
    product_o = acc_q;
  end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Directed testbench for booth_r4_ctrl with a behavioural 16-bit adder
// closing the loop on the adder pins.
module tb_booth_r4_ctrl;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] addA;
  logic [15:0] addB;
  logic        addCin;
  logic [15:0] addSum;

  int errorCount = 0;
  int checkCount = 0;

  logic [3:0]  runCin;
  logic [3:0]  runBusy;
  logic [3:0]  runDone;
  logic [15:0] runAddB [4];
  logic [15:0] runAddA0;
  logic        doneSeen;
  logic [15:0] productAtDone;
  logic [15:0] addBAtDone;

  logic [11:0] busyVec;
  logic [11:0] doneVec;
  logic [3:0]  abortDone;

  booth_r4_ctrl dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .start_i   (start),
    .mcand_i   (mcand),
    .mplier_i  (mplier),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product),
    .add_a_o   (addA),
    .add_b_o   (addB),
    .add_cin_o (addCin),
    .add_sum_i (addSum)
  );

  // The carry-look-ahead adder the stage feeds, modelled as a plain sum.
  assign addSum = addA + addB + {15'd0, addCin};

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one multiplication from an IDLE negedge up to the DONE negedge,
  // recording the adder pins in each of the four RUN cycles.
  task automatic applyStimulus(input logic [7:0] mc, input logic [7:0] mp);
    start  = 1'b1;
    mcand  = mc;
    mplier = mp;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start    = 1'b0;
        runAddA0 = addA;
      end
      runCin[k]  = addCin;
      runBusy[k] = busy;
      runDone[k] = done;
      runAddB[k] = addB;
    end
    @(negedge clk);
    doneSeen      = done;
    productAtDone = product;
    addBAtDone    = addB;
  endtask

  // Checks the cycle after DONE: back in IDLE, no second done, product held.
  task automatic checkIdleAfter(input string tag, input logic [15:0] expProduct);
    @(negedge clk);
    checkOutput({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_idle_prod"}, {16'd0, product}, {16'd0, expProduct});
  endtask

  initial begin
    rstN   = 1'b0;
    start  = 1'b0;
    mcand  = 8'd0;
    mplier = 8'd0;

    #3;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_product", {16'd0, product}, 32'd0);
    checkOutput("rst_add_a", {16'd0, addA}, 32'd0);
    checkOutput("rst_add_b", {16'd0, addB}, 32'd0);
    checkOutput("rst_add_cin", {31'd0, addCin}, 32'd0);

    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // 7 x 3: digits -M, +M, 0, 0 -> 0x0015, done 5 cycles after acceptance.
    applyStimulus(8'd7, 8'd3);
    checkOutput("t1_busy_run", {28'd0, runBusy}, 32'hF);
    checkOutput("t1_done_run", {28'd0, runDone}, 32'h0);
    checkOutput("t1_done", {31'd0, doneSeen}, 32'd1);
    checkOutput("t1_product", {16'd0, productAtDone}, 32'h0015);
    checkOutput("t1_cin", {28'd0, runCin}, 32'h1);
    checkOutput("t1_addb0", {16'd0, runAddB[0]}, 32'hFFF8);
    checkOutput("t1_addb1", {16'd0, runAddB[1]}, 32'h001C);
    checkOutput("t1_adda0", {16'd0, runAddA0}, 32'h0);
    checkOutput("t1_addb_done", {16'd0, addBAtDone}, 32'h0);
    checkIdleAfter("t1", 16'h0015);

    // -128 x -128: only digit 3 is non-zero and it is -2M.
    applyStimulus(8'h80, 8'h80);
    checkOutput("t2_done", {31'd0, doneSeen}, 32'd1);
    checkOutput("t2_product", {16'd0, productAtDone}, 32'h4000);
    checkOutput("t2_addb3", {16'd0, runAddB[3]}, 32'h3FFF);
    checkOutput("t2_cin", {28'd0, runCin}, 32'h8);
    checkIdleAfter("t2", 16'h4000);

    // 127 x -128 and -1 x -1.
    applyStimulus(8'd127, 8'h80);
    checkOutput("t3_product", {16'd0, productAtDone}, 32'hC080);
    checkIdleAfter("t3", 16'hC080);
    applyStimulus(8'hFF, 8'hFF);
    checkOutput("t4_product", {16'd0, productAtDone}, 32'h0001);
    checkIdleAfter("t4", 16'h0001);

    // Zero multiplier: every digit is zero, adder b and carry stay low.
    applyStimulus(8'h5A, 8'h00);
    checkOutput("t5_product", {16'd0, productAtDone}, 32'h0000);
    checkOutput("t5_cin", {28'd0, runCin}, 32'h0);
    checkOutput("t5_addb_or", {16'd0, runAddB[0] | runAddB[1] | runAddB[2] | runAddB[3]}, 32'h0);
    checkIdleAfter("t5", 16'h0000);

    // Start held high: acceptances six cycles apart, busy low only in IDLE.
    start  = 1'b1;
    mcand  = 8'd5;
    mplier = 8'd6;
    busyVec = '0;
    doneVec = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      busyVec[11 - c] = busy;
      doneVec[11 - c] = done;
      if (done) begin
        checkOutput("t6_product", {16'd0, product}, 32'h001E);
      end
      if (c == 11) begin
        start = 1'b0;
      end
    end
    checkOutput("t6_busy_pattern", {20'd0, busyVec}, 32'hFBE);
    checkOutput("t6_done_pattern", {20'd0, doneVec}, 32'h082);
    @(negedge clk);

    // Reset in RUN cycle 2 aborts immediately with no done pulse.
    start  = 1'b1;
    mcand  = 8'd100;
    mplier = 8'h55;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t7_addb_pre", {16'd0, addB}, 32'h0640);
    rstN = 1'b0;
    #1;
    checkOutput("t7_busy", {31'd0, busy}, 32'd0);
    checkOutput("t7_done", {31'd0, done}, 32'd0);
    checkOutput("t7_product", {16'd0, product}, 32'd0);
    checkOutput("t7_add_a", {16'd0, addA}, 32'd0);
    checkOutput("t7_add_b", {16'd0, addB}, 32'd0);
    checkOutput("t7_add_cin", {31'd0, addCin}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    abortDone = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      abortDone[c] = done | busy;
    end
    checkOutput("t7_no_resume", {28'd0, abortDone}, 32'h0);

    // Fresh operation after the abort: 3 x -4.
    applyStimulus(8'd3, 8'hFC);
    checkOutput("t8_done", {31'd0, doneSeen}, 32'd1);
    checkOutput("t8_product", {16'd0, productAtDone}, 32'hFFF4);
    checkIdleAfter("t8", 16'hFFF4);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
